// File: rtl/timer_pkg.sv
// Shared constants and types for the timer input-capture block.
package timer_pkg;

    // Default count width and FIFO depth.
    localparam int BIT_DEF   = 32;
    localparam int DEPTH_DEF = 4;

    // Edge-select encodings for the Mode input.
    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // One capture entry at the default width; the FIFO word is packed in the
    // same order ({stamp, delta}) for any Bit.
    typedef struct packed {
        logic [BIT_DEF-1:0] stamp;
        logic [BIT_DEF-1:0] delta;
    } cap_entry_t;

endpackage

// File: rtl/cap_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
//
// Handshake: a push happens when wr=1 and (full=0 or a pop happens in the same
// cycle); a pop happens when rd=1 and empty=0. rd while empty is ignored, wr
// while full without a pop is ignored (the caller flags the loss). dout holds
// the head entry whenever empty=0 and only changes on a pop or a push into an
// empty FIFO.
module cap_fifo
    import timer_pkg::*;
#(
    parameter int W     = 2 * BIT_DEF,
    parameter int Depth = DEPTH_DEF
) (
    input  logic                     Clk,
    input  logic                     Clr,
    input  logic                     wr,
    input  logic [W-1:0]             din,
    input  logic                     rd,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);

    localparam int AW = $clog2(Depth);

    logic [W-1:0]  mem [Depth];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW-1:0] rptr_nx;
    logic [AW:0]   count_q;
    logic [W-1:0]  head_q;
    logic [W-1:0]  head_d;
    logic          push;
    logic          pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(Depth));
    assign pop   = rd & ~empty;
    assign push  = wr & (~full | pop);
    assign rptr_nx = rptr_q + 1'b1;

    assign dout  = head_q;
    assign count = count_q;

    // Storage array; written only on an accepted push.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem[wptr_q] <= din;
        end
    end

    // Next head word: the following entry on a pop, or the incoming word when
    // it becomes the only entry.
    always_comb begin
        head_d = head_q;
        if (pop) begin
            if (count_q == (AW+1)'(1)) begin
                if (push) begin
                    head_d = din;
                end
            end else begin
                head_d = mem[rptr_nx];
            end
        end else if (empty && push) begin
            head_d = din;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            head_q  <= '0;
        end else begin
            head_q <= head_d;
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_nx;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/timer_capture.sv
// Input-capture unit: timestamps synchronized edges of Sig with the Tin count
// and the interval since the previous accepted capture, queued in a FIFO.
module timer_capture
    import timer_pkg::*;
#(
    parameter int Bit   = BIT_DEF,
    parameter int Depth = DEPTH_DEF
) (
    input  logic                   Clk,
    input  logic                   Clr,
    input  logic                   Enable,
    input  logic [1:0]             Mode,
    input  logic [Bit-1:0]         Tin,
    input  logic                   Sig,
    input  logic                   Rd,
    input  logic                   Ovf_Clr,
    output logic [Bit-1:0]         Stamp,
    output logic [Bit-1:0]         Delta,
    output logic                   Empty,
    output logic                   Full,
    output logic [$clog2(Depth):0] Count,
    output logic                   Ovf
);

    logic           s1;
    logic           s2;
    logic           s3;
    logic           rise;
    logic           fall;
    logic           rise_en;
    logic           fall_en;
    logic           cap;
    logic           accept;
    logic           drop;
    logic [Bit-1:0] last_q;
    logic [Bit-1:0] delta_new;
    logic [2*Bit-1:0] head;

    // Three-flop synchronizer; runs regardless of Enable so that re-enabling
    // never sees a stale level as an edge.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= Sig;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise    = s2 & ~s3;
    assign fall    = ~s2 & s3;
    assign rise_en = (Mode == MODE_RISE) | (Mode == MODE_BOTH);
    assign fall_en = (Mode == MODE_FALL) | (Mode == MODE_BOTH);
    assign cap     = Enable & ((rise_en & rise) | (fall_en & fall));

    // A capture is lost only when the FIFO is full and nothing leaves it this
    // cycle (Rd while full always pops).
    assign drop      = cap & Full & ~Rd;
    assign accept    = cap & ~drop;
    assign delta_new = Tin - last_q;

    // Reference for the next interval; moves only on an accepted capture.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            last_q <= '0;
        end else if (accept) begin
            last_q <= Tin;
        end
    end

    // Sticky overflow; a same-cycle drop beats Ovf_Clr.
    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            Ovf <= 1'b0;
        end else if (drop) begin
            Ovf <= 1'b1;
        end else if (Ovf_Clr) begin
            Ovf <= 1'b0;
        end
    end

    cap_fifo #(
        .W     (2 * Bit),
        .Depth (Depth)
    ) u_fifo (
        .Clk   (Clk),
        .Clr   (Clr),
        .wr    (cap),
        .din   ({Tin, delta_new}),
        .rd    (Rd),
        .dout  (head),
        .full  (Full),
        .empty (Empty),
        .count (Count)
    );

    assign Stamp = head[2*Bit-1:Bit];
    assign Delta = head[Bit-1:0];

endmodule

// File: tb/tb_timer_capture.sv
// Directed bench for timer_capture with hand-computed expected entries.
module tb_timer_capture;
    import timer_pkg::*;

    logic        Clk;
    logic        Clr;
    logic        Enable;
    logic [1:0]  Mode;
    logic [31:0] Tin;
    logic        Sig;
    logic        Rd;
    logic        Ovf_Clr;
    logic [31:0] Stamp;
    logic [31:0] Delta;
    logic        Empty;
    logic        Full;
    logic [2:0]  Count;
    logic        Ovf;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];

    timer_capture #(.Bit(32), .Depth(4)) dut (
        .Clk     (Clk),
        .Clr     (Clr),
        .Enable  (Enable),
        .Mode    (Mode),
        .Tin     (Tin),
        .Sig     (Sig),
        .Rd      (Rd),
        .Ovf_Clr (Ovf_Clr),
        .Stamp   (Stamp),
        .Delta   (Delta),
        .Empty   (Empty),
        .Full    (Full),
        .Count   (Count),
        .Ovf     (Ovf)
    );

    // Clock
    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Toggle Sig; the capture (if any) lands on the third edge, where Tin=tin.
    task automatic cap_edge(input logic [31:0] tin, input logic with_rd);
        Sig = ~Sig;
        tick();
        tick();
        Tin = tin;
        Rd  = with_rd;
        tick();
        Rd  = 1'b0;
    endtask

    task automatic pop();
        Rd = 1'b1;
        tick();
        Rd = 1'b0;
    endtask

    initial begin
        logic [63:0] e;

        Clr = 1'b0; Enable = 1'b0; Mode = MODE_OFF; Tin = '0;
        Sig = 1'b0; Rd = 1'b0; Ovf_Clr = 1'b0;
        tick();
        tick();
        check("rst_stamp", Stamp, 32'd0);
        check("rst_delta", Delta, 32'd0);
        check("rst_empty", 32'(Empty), 32'd1);
        check("rst_full", 32'(Full), 32'd0);
        check("rst_count", 32'(Count), 32'd0);
        check("rst_ovf", 32'(Ovf), 32'd0);

        // Release with Sig already high: one rising edge, captured at Tin=102.
        Sig = 1'b1; Mode = MODE_RISE; Enable = 1'b1; Tin = 100; Clr = 1'b1;
        tick();
        Tin = 101;
        tick();
        check("rel_not_yet", 32'(Empty), 32'd1);
        Tin = 102;
        tick();
        check("rel_count", 32'(Count), 32'd1);
        check("rel_stamp", Stamp, 32'd102);
        check("rel_delta", Delta, 32'd102);

        // Asynchronous reset with an entry present.
        Clr = 1'b0;
        #1;
        check("arst_count", 32'(Count), 32'd0);
        check("arst_empty", 32'(Empty), 32'd1);
        check("arst_stamp", Stamp, 32'd0);
        check("arst_delta", Delta, 32'd0);
        tick();
        Sig = 1'b0;
        Clr = 1'b1;
        tick(); tick(); tick();

        // Rising-only mode.
        cap_edge(32'd1000, 1'b0);
        check("rise1_count", 32'(Count), 32'd1);
        check("rise1_stamp", Stamp, 32'd1000);
        check("rise1_delta", Delta, 32'd1000);
        cap_edge(32'd1100, 1'b0);
        check("fall_ignored", 32'(Count), 32'd1);
        cap_edge(32'd1250, 1'b0);
        check("rise2_count", 32'(Count), 32'd2);
        check("rise2_head", Stamp, 32'd1000);
        pop();
        check("rise2_stamp", Stamp, 32'd1250);
        check("rise2_delta", Delta, 32'd250);
        check("rise2_cnt1", 32'(Count), 32'd1);
        pop();
        check("rise_drained", 32'(Empty), 32'd1);

        // Both edges, wrap-around interval, latency.
        Mode = MODE_BOTH;
        Sig = 1'b0;
        tick();
        tick();
        check("lat_2edges", 32'(Count), 32'd0);
        Tin = 32'hFFFF_FFF0;
        tick();
        check("lat_3edges", 32'(Count), 32'd1);
        check("wrap1_stamp", Stamp, 32'hFFFF_FFF0);
        check("wrap1_delta", Delta, 32'hFFFF_FB0E);
        pop();
        cap_edge(32'h0000_0010, 1'b0);
        check("wrap2_stamp", Stamp, 32'h0000_0010);
        check("wrap2_delta", Delta, 32'h0000_0020);
        pop();

        // Overflow: four captures fill, fifth is dropped.
        cap_edge(32'd2000, 1'b0); exp_q.push_back({32'd2000, 32'd1984});
        cap_edge(32'd2010, 1'b0); exp_q.push_back({32'd2010, 32'd10});
        cap_edge(32'd2030, 1'b0); exp_q.push_back({32'd2030, 32'd20});
        cap_edge(32'd2060, 1'b0); exp_q.push_back({32'd2060, 32'd30});
        check("fill_full", 32'(Full), 32'd1);
        check("fill_count", 32'(Count), 32'd4);
        check("fill_ovf", 32'(Ovf), 32'd0);
        cap_edge(32'd2100, 1'b0);
        check("drop_ovf", 32'(Ovf), 32'd1);
        check("drop_count", 32'(Count), 32'd4);
        check("drop_head", Stamp, 32'd2000);
        check("drop_head_delta", Delta, 32'd1984);

        // Capture and pop while full; last is still 2060.
        cap_edge(32'd2200, 1'b1);
        e = exp_q.pop_front();
        exp_q.push_back({32'd2200, 32'd140});
        check("cp_count", 32'(Count), 32'd4);
        check("cp_ovf", 32'(Ovf), 32'd1);
        check("cp_head", Stamp, 32'd2010);

        // Drop and Ovf_Clr in the same cycle: set wins.
        Sig = ~Sig;
        tick();
        tick();
        Tin = 32'd2300;
        Ovf_Clr = 1'b1;
        tick();
        Ovf_Clr = 1'b0;
        check("setwins_ovf", 32'(Ovf), 32'd1);
        check("setwins_count", 32'(Count), 32'd4);
        Ovf_Clr = 1'b1;
        tick();
        Ovf_Clr = 1'b0;
        check("ovf_clr", 32'(Ovf), 32'd0);

        // Drain against the expected queue.
        for (int i = 0; i < 4; i++) begin
            e = exp_q.pop_front();
            check("drain_stamp", Stamp, e[63:32]);
            check("drain_delta", Delta, e[31:0]);
            pop();
        end
        check("drain_empty", 32'(Empty), 32'd1);

        // Empty corner cases.
        pop();
        check("rd_empty_count", 32'(Count), 32'd0);
        check("rd_empty_ovf", 32'(Ovf), 32'd0);
        cap_edge(32'd3000, 1'b1);
        check("wr_rd_empty_count", 32'(Count), 32'd1);
        check("wr_rd_empty_stamp", Stamp, 32'd3000);
        check("wr_rd_empty_delta", Delta, 32'd800);

        // Enable gating.
        Enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            Sig = ~Sig;
            tick(); tick(); tick();
        end
        check("dis_count", 32'(Count), 32'd1);
        check("dis_stamp", Stamp, 32'd3000);
        pop();
        check("dis_pop", 32'(Empty), 32'd1);
        Enable = 1'b1;
        tick(); tick(); tick();
        check("reen_no_phantom", 32'(Count), 32'd0);
        cap_edge(32'd3500, 1'b0);
        check("reen_count", 32'(Count), 32'd1);
        check("reen_stamp", Stamp, 32'd3500);
        check("reen_delta", Delta, 32'd500);

        // Mode off blocks captures.
        Mode = MODE_OFF;
        cap_edge(32'd4000, 1'b0);
        check("off_count", 32'(Count), 32'd1);
        check("off_stamp", Stamp, 32'd3500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/timer_capture.md
# timer_capture

Input-capture unit that reads a free-running `Timer` count and timestamps edges of an external signal (encoder index, IR ball sensor, infrared beam break). Each accepted edge stores the current count plus the modulo-2^Bit interval since the previous accepted edge in a small FWFT FIFO, which the host logic drains through a one-cycle read strobe. It sits beside the timer, on the consumer side of its count bus.

## Interface
- `Bit`, 32: width of the timer count and of both stored fields.
- `Depth`, 4: FIFO entries; a power of two, at least 2.
- `Clk` input 1: sole clock, rising edge.
- `Clr` input 1: reset, asynchronous, active-low.
- `Enable` input 1: capture enable; low suppresses new captures only.
- `Mode` input 2: 00 off, 01 rising, 10 falling, 11 both edges.
- `Tin` input Bit: timer count, synchronous to `Clk`.
- `Sig` input 1: asynchronous signal to be timestamped.
- `Rd` input 1: pop strobe; one pop per high cycle.
- `Ovf_Clr` input 1: clears the sticky overflow flag.
- `Stamp` output Bit: timestamp of the FIFO head.
- `Delta` output Bit: interval of the FIFO head.
- `Empty` output 1: FIFO holds 0 entries.
- `Full` output 1: FIFO holds `Depth` entries.
- `Count` output clog2(Depth)+1: number of entries.
- `Ovf` output 1: sticky flag; a capture was dropped.

## Operation
- **Synchronizer.** `Sig` passes through flops s1→s2→s3, all reset to 0. `rise = s2 & ~s3`; `fall = ~s2 & s3`.
- **Capture condition.** `cap = Enable & ((Mode[0] & rise) | (Mode[1] & fall))`. The synchronizer always runs, so raising `Enable` never creates a phantom edge.
- **Accepted capture.** Writes {`Tin`, `Tin - last`} into the FIFO, then sets `last <= Tin`.
  - The subtraction wraps modulo 2^Bit; for example, last=0xFFFFFFF0 and Tin=0x10 gives Delta=0x20.
  - `last` resets to 0, so the first Delta after reset equals its Stamp.
- **Dropped capture.** A capture arriving while Full and without a same-cycle pop is dropped. It sets `Ovf` and leaves `last` unchanged.
- **Read.** `Rd` with `Empty=0` pops the head. `Rd` while Empty is ignored and has no error effect.
- **Simultaneous events.**
  - Capture + pop while Full: both happen; no overflow; Count stays unchanged.
  - Capture + `Rd` while Empty: the write is accepted and the read is ignored; Count becomes 1.
  - Capture + `Ovf_Clr` while Full with no pop: `Ovf` stays set (set wins).
- **Disable/off.** `Enable=0` or `Mode=00` blocks captures. FIFO contents, `last` and `Ovf` are kept, and reads still work.
- **Reset values.**
  - Asserting `Clr` at any time, including mid-capture or mid-read, immediately gives: FIFO empty, Stamp=Delta=0, Empty=1, Full=0, Count=0, Ovf=0, last=0, s1..s3=0.
  - If `Sig` is high at reset release, one rising edge is detected, and it is captured if Mode[0]=1 and Enable=1.

## Timing
- `Sig` is first sampled at edge k. s2 is high after edge k+1. The capture writes the `Tin` value present at edge k+2.
  - Stamp, Delta, Count and Empty update after edge k+2.
  - `Sig` change to visible output: 2–3 cycles.
- Edges spaced 1 cycle apart at s2 are each captured in consecutive cycles. Pulses shorter than one `Clk` period may be lost.
- **Pop.** A `Rd` high at edge n updates the head and Count after edge n. Stamp and Delta are registered FWFT outputs, valid whenever Empty=0 and stable until the next pop.
- `Ovf` rises one cycle after the dropped capture's edge. `Ovf_Clr` takes effect at the next edge.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `timer_pkg` holds:
  - `MODE_OFF`, `MODE_RISE`, `MODE_FALL`, `MODE_BOTH` (2-bit);
  - the default `Bit`/`Depth`;
  - the packed capture-entry type {stamp, delta}.
- Sub-module `cap_fifo`:
  - synchronous FWFT FIFO, width 2*Bit, depth `Depth`;
  - async active-low `Clr`;
  - wr/rd/full/empty/count.
- Synchronizer, edge detect, `last` register and overflow flag stay in `timer_capture`.

## Test plan
- **Reset.** Assert Clr with Sig=0 -> all outputs 0, Empty=1. Release with Sig=1, Mode=01, Enable=1, Tin=100+cycle -> exactly one capture; Stamp equals the Tin sampled 2 edges after release (Tin=102); Delta equals Stamp.
- **Rising edges.** Mode=01; rising edges with Tin=1000 and Tin=1250 -> entries {1000,1000} and {1250,250}. Falling edges produce no captures.
- **Both edges / wrap.** Mode=11; captures at Tin=0xFFFFFFF0 and then 0x00000010 -> second Delta=0x20. Capture latency measured as 2–3 cycles from the Sig change.
- **Overflow.** Depth=4; 5 edges without reads -> Full=1, Count=4, Ovf=1; the 5th edge is dropped; Deltas of the first 4 are correct. A subsequent pop+capture in the same cycle -> Count=4, Ovf unchanged. `Ovf_Clr` -> Ovf=0.
- **Empty corner.** `Rd` while Empty -> no change. Capture+`Rd` in the same cycle while Empty -> Count=1, entry present.
- **Enable gating.** Enable=0 while Sig toggles -> no captures, contents retained, reads succeed. Enable back to 1 with Sig high -> no capture until the next genuine edge.
